// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon-MM bus arbiter.
// Both requesters and the FSM states are named here so the top and bench agree on encoding.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      BUS_IDLE,
      BUS_BUSY,
      BUS_RESP
   } bus_state_t;

   typedef enum logic {
      GNT_IF,
      GNT_D
   } grant_t;

   localparam logic [3:0] BE_ALL = 4'b1111;

   function automatic grant_t other_side(input grant_t g);
      return (g == GNT_IF) ? GNT_D : GNT_IF;
   endfunction

endpackage

// File: rtl/mips_bus_watchdog.sv
// Counts stalled bus cycles of the current access; expired flags the wait cycle that hits the limit.
// A TIMEOUT_CYCLES of 0 turns the watchdog off entirely.
module mips_bus_watchdog #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

   logic [CW-1:0] count;

   // Expiry is combinational so the arbiter aborts on the same edge the last allowed wait cycle ends
   assign expired = (TIMEOUT_CYCLES != 0) && enable &&
                    (count == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-MM master between instruction fetch and load/store, one access at a time.
// Every output is registered; the FSM walks IDLE -> BUSY -> RESP for each access.
module mips_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 256,
   parameter logic [3:0] FETCH_BE       = BE_ALL
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   bus_state_t  state, state_n;
   grant_t      gnt, gnt_n, rr_ptr, rr_n, pick;
   logic [31:0] address_n, writedata_n, if_rdata_n, d_rdata_n;
   logic [3:0]  be_n;
   logic        read_n, write_n, if_ack_n, d_ack_n, err_n;
   logic        wd_clear, wd_expired;

   // Word alignment drops the low address bits on purpose
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

   mips_bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (wd_clear),
      .enable ((state == BUS_BUSY) && waitrequest),
      .expired(wd_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= BUS_IDLE;
         gnt        <= GNT_IF;
         rr_ptr     <= GNT_IF;
         address    <= '0;
         read       <= 1'b0;
         write      <= 1'b0;
         writedata  <= '0;
         byteenable <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         if_ack     <= 1'b0;
         d_ack      <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         gnt        <= gnt_n;
         rr_ptr     <= rr_n;
         address    <= address_n;
         read       <= read_n;
         write      <= write_n;
         writedata  <= writedata_n;
         byteenable <= be_n;
         if_rdata   <= if_rdata_n;
         d_rdata    <= d_rdata_n;
         if_ack     <= if_ack_n;
         d_ack      <= d_ack_n;
         err        <= err_n;
      end
   end

   always_comb begin
      state_n     = state;
      gnt_n       = gnt;
      rr_n        = rr_ptr;
      pick        = GNT_IF;
      address_n   = address;
      read_n      = read;
      write_n     = write;
      writedata_n = writedata;
      be_n        = byteenable;
      if_rdata_n  = if_rdata;
      d_rdata_n   = d_rdata;
      if_ack_n    = 1'b0;
      d_ack_n     = 1'b0;
      err_n       = 1'b0;
      wd_clear    = 1'b0;

      case (state)
         BUS_IDLE: begin
            if (if_req || d_req) begin
               // The round-robin pointer only moves when both sides compete
               if (if_req && d_req) begin
                  pick = rr_ptr;
                  rr_n = other_side(rr_ptr);
               end else begin
                  pick = if_req ? GNT_IF : GNT_D;
               end
               gnt_n    = pick;
               wd_clear = 1'b1;
               state_n  = BUS_BUSY;
               if (pick == GNT_IF) begin
                  address_n = {if_addr[31:2], 2'b00};
                  be_n      = FETCH_BE;
                  read_n    = 1'b1;
                  write_n   = 1'b0;
               end else begin
                  address_n   = {d_addr[31:2], 2'b00};
                  writedata_n = d_wdata;
                  be_n        = d_be;
                  read_n      = !d_we;
                  write_n     = d_we;
               end
            end
         end
         BUS_BUSY: begin
            if (!waitrequest || wd_expired) begin
               read_n  = 1'b0;
               write_n = 1'b0;
               state_n = BUS_RESP;
               err_n   = waitrequest;
               if (gnt == GNT_IF) begin
                  if_ack_n = 1'b1;
               end else begin
                  d_ack_n = 1'b1;
               end
               // An aborted access must not disturb the previously returned data
               if (read && !waitrequest) begin
                  if (gnt == GNT_IF) begin
                     if_rdata_n = readdata;
                  end else begin
                     d_rdata_n = readdata;
                  end
               end
            end
         end
         BUS_RESP: begin
            state_n = BUS_IDLE;
         end
         default: begin
            state_n = BUS_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter with a short watchdog so timeouts are reachable.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mips_bus_arbiter;

   logic        clk, rst;
   logic        if_req, if_ack, d_req, d_we, d_ack, err;
   logic        read, write, waitrequest;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic [31:0] address, writedata, readdata;
   logic [3:0]  d_be, byteenable;

   int n_cmp  = 0;
   int n_fail = 0;

   mips_bus_arbiter #(
      .TIMEOUT_CYCLES(8),
      .FETCH_BE      (4'b1111)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_ack     (if_ack),
      .if_rdata   (if_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_be       (d_be),
      .d_ack      (d_ack),
      .d_rdata    (d_rdata),
      .err        (err),
      .address    (address),
      .read       (read),
      .write      (write),
      .writedata  (writedata),
      .byteenable (byteenable),
      .waitrequest(waitrequest),
      .readdata   (readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
      waitrequest = 1'b0; readdata = '0;
      tick; tick;
      n_cmp++; if ({read, write, if_ack, d_ack, err} !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %b want 00000", {read, write, if_ack, d_ack, err}); end
      n_cmp++; if (address !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_address: got %h want 0", address); end
      n_cmp++; if ({writedata, byteenable} !== 36'h0) begin n_fail++; $display("[TB] FAIL reset_wdata_be: got %h want 0", {writedata, byteenable}); end
      n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata}); end
      #2 rst = 1'b1;
      tick;
      n_cmp++; if ({read, write, if_ack, d_ack} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_idle: got %b want 0000", {read, write, if_ack, d_ack}); end
   endtask

   task automatic test_fetch;
      if_req = 1'b1; if_addr = 32'hBFC00000; waitrequest = 1'b0; readdata = 32'h24020005;
      tick;
      n_cmp++; if ({read, write} !== 2'b10) begin n_fail++; $display("[TB] FAIL fetch_rw: got %b want 10", {read, write}); end
      n_cmp++; if (address !== 32'hBFC00000) begin n_fail++; $display("[TB] FAIL fetch_addr: got %h want bfc00000", address); end
      n_cmp++; if (byteenable !== 4'hF) begin n_fail++; $display("[TB] FAIL fetch_be: got %h want f", byteenable); end
      n_cmp++; if (if_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_early_ack: got %b want 0", if_ack); end
      tick;
      n_cmp++; if ({read, if_ack, d_ack} !== 3'b010) begin n_fail++; $display("[TB] FAIL fetch_ack: got %b want 010", {read, if_ack, d_ack}); end
      n_cmp++; if (if_rdata !== 32'h24020005) begin n_fail++; $display("[TB] FAIL fetch_rdata: got %h want 24020005", if_rdata); end
      if_req = 1'b0;
      tick;
      n_cmp++; if ({read, if_ack} !== 2'b00) begin n_fail++; $display("[TB] FAIL fetch_ack_width: got %b want 00", {read, if_ack}); end
   endtask

   task automatic test_wait_load;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00000204; d_be = 4'hF;
      waitrequest = 1'b1; readdata = 32'hDEADBEEF;
      tick;
      for (int c = 0; c < 4; c++) begin
         n_cmp++; if ({read, write, d_ack} !== 3'b100) begin n_fail++; $display("[TB] FAIL wait_hold_ctrl[%0d]: got %b want 100", c, {read, write, d_ack}); end
         n_cmp++; if (address !== 32'h00000204) begin n_fail++; $display("[TB] FAIL wait_hold_addr[%0d]: got %h want 00000204", c, address); end
         if (c == 3) begin waitrequest = 1'b0; readdata = 32'hCAFEF00D; end
         tick;
      end
      n_cmp++; if ({read, d_ack, err} !== 3'b010) begin n_fail++; $display("[TB] FAIL wait_ack: got %b want 010", {read, d_ack, err}); end
      n_cmp++; if (d_rdata !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL wait_rdata: got %h want cafef00d", d_rdata); end
      d_req = 1'b0;
      tick;
      n_cmp++; if (d_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL wait_ack_width: got %b want 0", d_ack); end
   endtask

   task automatic test_round_robin;
      logic        exp_if;
      logic [31:0] exp_addr, exp_data;
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h00000100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00000208; d_be = 4'h5;
      waitrequest = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_if   = (k % 2 == 0);
         exp_addr = exp_if ? 32'h00000100 : 32'h00000208;
         exp_data = 32'hA0000000 + k;
         tick;
         n_cmp++; if ({read, write} !== 2'b10) begin n_fail++; $display("[TB] FAIL rr_rw[%0d]: got %b want 10", k, {read, write}); end
         n_cmp++; if (address !== exp_addr) begin n_fail++; $display("[TB] FAIL rr_addr[%0d]: got %h want %h", k, address, exp_addr); end
         readdata = exp_data;
         tick;
         n_cmp++; if ({if_ack, d_ack} !== {exp_if, !exp_if}) begin n_fail++; $display("[TB] FAIL rr_ack[%0d]: got %b want %b", k, {if_ack, d_ack}, {exp_if, !exp_if}); end
         n_cmp++; if ((exp_if ? if_rdata : d_rdata) !== exp_data) begin n_fail++; $display("[TB] FAIL rr_rdata[%0d]: got %h want %h", k, exp_if ? if_rdata : d_rdata, exp_data); end
         tick;
         n_cmp++; if ({if_ack, d_ack, read, write} !== 4'b0) begin n_fail++; $display("[TB] FAIL rr_resp[%0d]: got %b want 0000", k, {if_ack, d_ack, read, write}); end
      end
      if_req = 1'b0; d_req = 1'b0;
      tick;
   endtask

   task automatic test_store;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h00001003; d_be = 4'b0011;
      d_wdata = 32'h12345678; waitrequest = 1'b0; readdata = 32'h55555555;
      tick;
      n_cmp++; if ({read, write} !== 2'b01) begin n_fail++; $display("[TB] FAIL store_rw: got %b want 01", {read, write}); end
      n_cmp++; if (address !== 32'h00001000) begin n_fail++; $display("[TB] FAIL store_addr: got %h want 00001000", address); end
      n_cmp++; if (byteenable !== 4'b0011) begin n_fail++; $display("[TB] FAIL store_be: got %b want 0011", byteenable); end
      n_cmp++; if (writedata !== 32'h12345678) begin n_fail++; $display("[TB] FAIL store_wdata: got %h want 12345678", writedata); end
      tick;
      n_cmp++; if ({write, d_ack, err} !== 3'b010) begin n_fail++; $display("[TB] FAIL store_ack: got %b want 010", {write, d_ack, err}); end
      n_cmp++; if (d_rdata !== 32'hA0000003) begin n_fail++; $display("[TB] FAIL store_rdata_kept: got %h want a0000003", d_rdata); end
      d_req = 1'b0; d_we = 1'b0;
      tick;
   endtask

   task automatic test_timeout;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00000300; d_be = 4'hF;
      waitrequest = 1'b1; readdata = 32'h77777777;
      tick;
      for (int c = 0; c < 8; c++) begin
         n_cmp++; if ({read, d_ack, err} !== 3'b100) begin n_fail++; $display("[TB] FAIL timeout_wait[%0d]: got %b want 100", c, {read, d_ack, err}); end
         tick;
      end
      n_cmp++; if ({read, d_ack, err} !== 3'b011) begin n_fail++; $display("[TB] FAIL timeout_abort: got %b want 011", {read, d_ack, err}); end
      n_cmp++; if (d_rdata !== 32'hA0000003) begin n_fail++; $display("[TB] FAIL timeout_rdata_kept: got %h want a0000003", d_rdata); end
      d_req = 1'b0; waitrequest = 1'b0;
      tick;
      n_cmp++; if ({d_ack, err} !== 2'b00) begin n_fail++; $display("[TB] FAIL timeout_pulse: got %b want 00", {d_ack, err}); end
      if_req = 1'b1; if_addr = 32'h00000040; readdata = 32'h0BADCAFE;
      tick;
      n_cmp++; if ({read, address} !== {1'b1, 32'h00000040}) begin n_fail++; $display("[TB] FAIL after_timeout_grant: got %h want 100000040", {read, address}); end
      tick;
      n_cmp++; if ({if_ack, err, if_rdata} !== {2'b10, 32'h0BADCAFE}) begin n_fail++; $display("[TB] FAIL after_timeout_ack: got %h want 20badcafe", {if_ack, err, if_rdata}); end
      if_req = 1'b0;
      tick;
   endtask

   task automatic test_async_reset;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00000400; waitrequest = 1'b1;
      tick;
      n_cmp++; if ({read, address} !== {1'b1, 32'h00000400}) begin n_fail++; $display("[TB] FAIL arst_pre: got %h want 100000400", {read, address}); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if ({read, write, address} !== 34'h0) begin n_fail++; $display("[TB] FAIL arst_immediate: got %h want 0", {read, write, address}); end
      n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("[TB] FAIL arst_rdata: got %h want 0", {if_rdata, d_rdata}); end
      d_req = 1'b0; waitrequest = 1'b0;
      #3 rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick;
         n_cmp++; if ({read, write, if_ack, d_ack, err} !== 5'b0) begin n_fail++; $display("[TB] FAIL arst_idle[%0d]: got %b want 00000", c, {read, write, if_ack, d_ack, err}); end
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_wait_load();
      test_round_robin();
      test_store();
      test_timeout();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   always @(negedge clk) begin
      if (rst && read && write) begin
         n_fail++;
         $display("[TB] FAIL read_write_exclusive: got read=%b write=%b want not both", read, write);
      end
      if (rst && if_ack && d_ack) begin
         n_fail++;
         $display("[TB] FAIL ack_exclusive: got if_ack=%b d_ack=%b want not both", if_ack, d_ack);
      end
   end

endmodule
